// File: rtl/layer_4_pass_scheduler.sv
// ---------------------------------------------------------------------------
// layer_4_pass_scheduler
//   Sequences one convolution layer through the shared featuremap array, one
//   output-channel group (pass) at a time: issues input-buffer reads, aligns
//   fm_valid_in with the buffer read latency, counts returning output pixels,
//   generates output-buffer write addresses and detects drain stalls.
//
// Ports
//   Clk, Rst      clock (rising edge), asynchronous active-low reset
//   start         one-cycle start pulse, honoured only while idle
//   fm_ready      array can accept a pixel this cycle
//   fm_valid_out  array produced one output pixel
//   rd_en/rd_addr input-buffer read strobe and pixel address
//   fm_valid_in   rd_en delayed by RD_LATENCY cycles
//   wr_en/wr_addr output-buffer write strobe and address (combinational)
//   pass_idx      current pass (weight bank / output region select)
//   busy, done    activity flag, one-cycle completion pulse
//   error         sticky drain-timeout flag, cleared by an accepted start
//
// Optional: define LAYER_SCHED_PERF_EN to add cycle_count and stall_count.
// ---------------------------------------------------------------------------
module layer_4_pass_scheduler #(
   parameter int unsigned IMG_SIZE   = 104,
   parameter int unsigned OUT_PIXELS = 10816,
   parameter int unsigned NUM_PASSES = 8,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned TIMEOUT    = 4096
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  start,
   input  logic                  fm_ready,
   input  logic                  fm_valid_out,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  fm_valid_in,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [7:0]            pass_idx,
   output logic                  busy,
   output logic                  done,
`ifdef LAYER_SCHED_PERF_EN
   output logic [31:0]           cycle_count,
   output logic [31:0]           stall_count,
`endif
   output logic                  error
);

   localparam int unsigned NUM_PIX = IMG_SIZE * IMG_SIZE;
   localparam int unsigned CNT_W   = $clog2(OUT_PIXELS + 1);
   localparam int unsigned IDLE_W  = $clog2(TIMEOUT + 1);

   localparam logic [ADDR_WIDTH-1:0] LAST_RD   = ADDR_WIDTH'(NUM_PIX - 1);
   localparam logic [CNT_W-1:0]      OUT_FULL  = CNT_W'(OUT_PIXELS);
   localparam logic [IDLE_W-1:0]     IDLE_MAX  = IDLE_W'(TIMEOUT);
   localparam logic [7:0]            LAST_PASS = 8'(NUM_PASSES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_DRAIN,
      S_NEXT,
      S_FINISH
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
   logic [RD_LATENCY-1:0]   vld_sr_q, vld_sr_d;
   logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
   logic [IDLE_W-1:0]       idle_cnt_q, idle_cnt_d;
   logic [7:0]              pass_q, pass_d;
   logic                    error_q, error_d;
   logic                    out_full;

   // State register
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         rd_addr_q  <= '0;
         vld_sr_q   <= '0;
         out_cnt_q  <= '0;
         idle_cnt_q <= '0;
         pass_q     <= '0;
         error_q    <= 1'b0;
      end else begin
         rd_addr_q  <= rd_addr_d;
         vld_sr_q   <= vld_sr_d;
         out_cnt_q  <= out_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         pass_q     <= pass_d;
         error_q    <= error_d;
      end
   end

   // Next-state, counters and strobes
   always_comb begin
      state_d    = state_q;
      rd_addr_d  = rd_addr_q;
      out_cnt_d  = out_cnt_q;
      idle_cnt_d = idle_cnt_q;
      pass_d     = pass_q;
      error_d    = error_q;
      rd_en      = 1'b0;
      wr_en      = 1'b0;

      rd_en = (state_q == S_STREAM) && fm_ready;
      wr_en = fm_valid_out && ((state_q == S_STREAM) || (state_q == S_DRAIN));

      // Saturate so stray extra pulses cannot wrap the count back below full
      if (wr_en && (out_cnt_q != OUT_FULL)) begin
         out_cnt_d = out_cnt_q + CNT_W'(1);
      end
      out_full = (out_cnt_d == OUT_FULL);

      // Delay line shifts every cycle regardless of state
      vld_sr_d = (vld_sr_q << 1) | RD_LATENCY'(rd_en);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_STREAM;
               rd_addr_d  = '0;
               out_cnt_d  = '0;
               idle_cnt_d = '0;
               pass_d     = '0;
               error_d    = 1'b0;
            end
         end
         S_STREAM: begin
            idle_cnt_d = '0;
            if (rd_en) begin
               if (rd_addr_q == LAST_RD) begin
                  rd_addr_d = '0;
                  // Outputs may already be complete; skip DRAIN then
                  state_d   = out_full ? S_NEXT : S_DRAIN;
               end else begin
                  rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
               end
            end
         end
         S_DRAIN: begin
            if (out_full) begin
               state_d = S_NEXT;
            end else if (fm_valid_out) begin
               idle_cnt_d = '0;
            end else begin
               idle_cnt_d = idle_cnt_q + IDLE_W'(1);
               if (idle_cnt_d == IDLE_MAX) begin
                  error_d = 1'b1;
                  state_d = S_FINISH;
               end
            end
         end
         S_NEXT: begin
            out_cnt_d = '0;
            if (pass_q == LAST_PASS) begin
               state_d = S_FINISH;
            end else begin
               pass_d  = pass_q + 8'd1;
               state_d = S_STREAM;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign rd_addr     = rd_addr_q;
   assign fm_valid_in = vld_sr_q[RD_LATENCY-1];
   assign wr_addr     = ADDR_WIDTH'(out_cnt_q);
   assign pass_idx    = pass_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_FINISH) && !error_q;
   assign error       = error_q;

`ifdef LAYER_SCHED_PERF_EN
   logic [31:0] cyc_cnt_q, cyc_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Busy-cycle and stream-stall counters, cleared on an accepted start
   always_comb begin
      cyc_cnt_d   = cyc_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if ((state_q == S_IDLE) && start) begin
         cyc_cnt_d   = '0;
         stall_cnt_d = '0;
      end else begin
         if (state_q != S_IDLE) begin
            cyc_cnt_d = cyc_cnt_q + 32'd1;
         end
         if ((state_q == S_STREAM) && !fm_ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         cyc_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         cyc_cnt_q   <= cyc_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign cycle_count = cyc_cnt_q;
   assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_layer_4_pass_scheduler.sv
// ---------------------------------------------------------------------------
// tb_layer_4_pass_scheduler
//   Directed bench. dut_a: IMG_SIZE=4, OUT_PIXELS=16, NUM_PASSES=2,
//   RD_LATENCY=1, TIMEOUT=8 with an array model that echoes fm_valid_in five
//   cycles later. dut_b: same but RD_LATENCY=3 with an array model that
//   returns all 16 outputs of a pass before the (throttled) reads finish.
// ---------------------------------------------------------------------------
module tb_layer_4_pass_scheduler;

   localparam int unsigned AW = 14;

   logic Clk = 1'b0;
   logic Rst = 1'b0;
   always #5 Clk = ~Clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- dut_a ----------------
   logic          start_a = 1'b0, ready_a = 1'b1, vo_a;
   logic          rd_en_a, vin_a, wr_en_a, busy_a, done_a, err_a;
   logic [AW-1:0] rd_addr_a, wr_addr_a;
   logic [7:0]    pass_a;
`ifdef LAYER_SCHED_PERF_EN
   logic [31:0]   cc_a, sc_a, cc_b, sc_b;
`endif

   layer_4_pass_scheduler #(.IMG_SIZE(4), .OUT_PIXELS(16), .NUM_PASSES(2),
                            .RD_LATENCY(1), .ADDR_WIDTH(AW), .TIMEOUT(8)) dut_a (
      .Clk(Clk), .Rst(Rst), .start(start_a), .fm_ready(ready_a),
      .fm_valid_out(vo_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
      .fm_valid_in(vin_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
      .pass_idx(pass_a), .busy(busy_a), .done(done_a),
`ifdef LAYER_SCHED_PERF_EN
      .cycle_count(cc_a), .stall_count(sc_a),
`endif
      .error(err_a));

   // Array model A: echo fm_valid_in after 5 cycles, at most lim_a pulses per run
   logic [4:0] echo_a = '0;
   int         em_a   = 0;
   int         lim_a  = 1000;
   assign vo_a = echo_a[4] && (em_a < lim_a);
   always @(posedge Clk) begin
      echo_a <= {echo_a[3:0], vin_a};
      if (start_a && !busy_a) em_a <= 0;
      else if (vo_a)          em_a <= em_a + 1;
   end

   // Monitor A: expected read/write address sequences kept by the bench
   bit   mon_a = 0;
   logic prev_rd_a = 1'b0, err_prev_a = 1'b0, done_prev_a = 1'b0;
   int   exp_rd_a, rd_pass_a, rd_cnt_a, exp_wr_a, wr_cnt_a, done_cnt_a;
   int   last_vo_a, err_cyc_a;

   always @(negedge Clk) begin
      if (mon_a) begin
         check("a_vin_lag1", 32'(vin_a), 32'(prev_rd_a));
         check("a_wr_en", 32'(wr_en_a), 32'(vo_a));
         if (rd_en_a) begin
            check("a_rd_addr", 32'(rd_addr_a), 32'(exp_rd_a));
            check("a_rd_pass", 32'(pass_a), 32'(rd_pass_a));
            rd_cnt_a++;
            if (exp_rd_a == 15) begin exp_rd_a = 0; rd_pass_a++; end
            else exp_rd_a++;
         end
         if (wr_en_a) begin
            check("a_wr_addr", 32'(wr_addr_a), 32'(exp_wr_a));
            wr_cnt_a++;
            exp_wr_a = (exp_wr_a == 15) ? 0 : exp_wr_a + 1;
         end
         if (vo_a) last_vo_a = cyc;
         if (err_a && !err_prev_a) err_cyc_a = cyc;
         if (done_a) begin
            done_cnt_a++;
            check("a_busy_at_done", 32'(busy_a), 32'd1);
         end
         if (done_prev_a) check("a_busy_after_done", 32'(busy_a), 32'd0);
         prev_rd_a   = rd_en_a;
         err_prev_a  = err_a;
         done_prev_a = done_a;
      end
   end

   task automatic clr_a;
      exp_rd_a = 0; rd_pass_a = 0; rd_cnt_a = 0; exp_wr_a = 0; wr_cnt_a = 0;
      done_cnt_a = 0; last_vo_a = -100; err_cyc_a = -1;
   endtask

   task automatic pulse_start_a;
      @(posedge Clk); #1 start_a = 1'b1;
      @(posedge Clk); #1 start_a = 1'b0;
   endtask

   task automatic wait_idle_a(input string tag, input int budget);
      int n = 0;
      @(negedge Clk);
      while (busy_a && n < budget) begin @(negedge Clk); n++; end
      check({tag, "_idle_in_budget"}, 32'(busy_a), 32'd0);
   endtask

   // ---------------- dut_b ----------------
   logic          start_b = 1'b0, ready_b, vo_b;
   logic          rd_en_b, vin_b, wr_en_b, busy_b, done_b, err_b;
   logic [AW-1:0] rd_addr_b, wr_addr_b;
   logic [7:0]    pass_b;

   layer_4_pass_scheduler #(.IMG_SIZE(4), .OUT_PIXELS(16), .NUM_PASSES(2),
                            .RD_LATENCY(3), .ADDR_WIDTH(AW), .TIMEOUT(8)) dut_b (
      .Clk(Clk), .Rst(Rst), .start(start_b), .fm_ready(ready_b),
      .fm_valid_out(vo_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
      .fm_valid_in(vin_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
      .pass_idx(pass_b), .busy(busy_b), .done(done_b),
`ifdef LAYER_SCHED_PERF_EN
      .cycle_count(cc_b), .stall_count(sc_b),
`endif
      .error(err_b));

   // Array model B: reads throttled to every other cycle; 16 outputs per pass
   // returned back-to-back right away, so outputs finish well before reads.
   assign ready_b = cyc[0];
   int         em_b = 16;
   logic [7:0] pass_q_b = '0;
   assign vo_b = busy_b && (em_b < 16);
   always @(posedge Clk) begin
      pass_q_b <= pass_b;
      if ((start_b && !busy_b) || (pass_b != pass_q_b)) em_b <= 0;
      else if (vo_b)                                    em_b <= em_b + 1;
   end

   bit         mon_b = 0;
   logic [2:0] h_b = '0;
   logic [7:0] pass_prev_b = '0;
   int exp_rd_b = 0, rd_pass_b = 0, rd_cnt_b = 0, exp_wr_b = 0, wr_cnt_b = 0;
   int rd_last_cyc_b = -1, pass_chg_cyc_b = -1, out_full_cyc_b = -1, done_cnt_b = 0;

   always @(negedge Clk) begin
      if (mon_b) begin
         check("b_vin_lag3", 32'(vin_b), 32'(h_b[2]));
         h_b = {h_b[1:0], rd_en_b};
         if (rd_en_b) begin
            check("b_rd_addr", 32'(rd_addr_b), 32'(exp_rd_b));
            check("b_rd_pass", 32'(pass_b), 32'(rd_pass_b));
            rd_cnt_b++;
            if (exp_rd_b == 15) begin
               exp_rd_b = 0;
               rd_pass_b++;
               if (rd_pass_b == 1) rd_last_cyc_b = cyc;
            end else exp_rd_b++;
         end
         if (wr_en_b) begin
            check("b_wr_addr", 32'(wr_addr_b), 32'(exp_wr_b));
            wr_cnt_b++;
            if (wr_cnt_b == 16) out_full_cyc_b = cyc;
            exp_wr_b = (exp_wr_b == 15) ? 0 : exp_wr_b + 1;
         end
         if (pass_b == 8'd1 && pass_prev_b == 8'd0) pass_chg_cyc_b = cyc;
         pass_prev_b = pass_b;
         if (done_b) done_cnt_b++;
      end
   end

   // Global watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      clr_a();
      repeat (3) @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);

      // Reset state
      check("rst_rd_en",   32'(rd_en_a),   32'd0);
      check("rst_rd_addr", 32'(rd_addr_a), 32'd0);
      check("rst_vin",     32'(vin_a),     32'd0);
      check("rst_wr_en",   32'(wr_en_a),   32'd0);
      check("rst_wr_addr", 32'(wr_addr_a), 32'd0);
      check("rst_pass",    32'(pass_a),    32'd0);
      check("rst_busy",    32'(busy_a),    32'd0);
      check("rst_done",    32'(done_a),    32'd0);
      check("rst_error",   32'(err_a),     32'd0);

      // T1: basic two-pass run, plus a start pulse during pass 1 that is ignored
      mon_a = 1;
      clr_a(); lim_a = 1000;
      pulse_start_a();
      @(negedge Clk);
      check("t1_first_rd_en",   32'(rd_en_a),   32'd1);
      check("t1_first_rd_addr", 32'(rd_addr_a), 32'd0);
      check("t1_busy",          32'(busy_a),    32'd1);
      check("t1_vin_not_yet",   32'(vin_a),     32'd0);
      n = 0;
      while (pass_a != 8'd1 && n < 200) begin @(negedge Clk); n++; end
      check("t1_reach_pass1", 32'(pass_a), 32'd1);
      @(posedge Clk); #1 start_a = 1'b1;
      @(posedge Clk); #1 start_a = 1'b0;
      wait_idle_a("t1", 300);
      check("t1_rd_count",  32'(rd_cnt_a),   32'd32);
      check("t1_wr_count",  32'(wr_cnt_a),   32'd32);
      check("t1_done_once", 32'(done_cnt_a), 32'd1);
      check("t1_pass_hold", 32'(pass_a),     32'd1);
      check("t1_no_error",  32'(err_a),      32'd0);

      // T2: fm_ready low on STREAM cycles 3 and 4
      clr_a();
      pulse_start_a();                  // now in STREAM cycle 1
      @(posedge Clk); #1;               // cycle 2
      @(posedge Clk); #1 ready_a = 1'b0; // cycle 3
      @(negedge Clk);
      check("t2_c3_rd_en",   32'(rd_en_a),   32'd0);
      check("t2_c3_rd_addr", 32'(rd_addr_a), 32'd2);
      @(posedge Clk); #1;               // cycle 4
      @(negedge Clk);
      check("t2_c4_rd_en",   32'(rd_en_a),   32'd0);
      check("t2_c4_rd_addr", 32'(rd_addr_a), 32'd2);
      @(posedge Clk); #1 ready_a = 1'b1; // cycle 5
      @(negedge Clk);
      check("t2_c5_rd_en",   32'(rd_en_a),   32'd1);
      check("t2_c5_rd_addr", 32'(rd_addr_a), 32'd2);
      wait_idle_a("t2", 300);
      check("t2_rd_count",  32'(rd_cnt_a),   32'd32);
      check("t2_done_once", 32'(done_cnt_a), 32'd1);

      // T3: only 10 of 16 outputs return -> drain timeout
      clr_a(); lim_a = 10;
      pulse_start_a();
      wait_idle_a("t3", 300);
      check("t3_wr_count",  32'(wr_cnt_a),   32'd10);
      check("t3_no_done",   32'(done_cnt_a), 32'd0);
      check("t3_error",     32'(err_a),      32'd1);
      // idle cycles strictly between last pulse and error becoming visible
      check("t3_timeout_gap", 32'(err_cyc_a - last_vo_a - 1), 32'd8);
      check("t3_pass_stuck",  32'(pass_a), 32'd0);
      clr_a(); lim_a = 1000;
      pulse_start_a();
      @(negedge Clk);
      check("t3_err_cleared", 32'(err_a), 32'd0);
      wait_idle_a("t3b", 300);
      check("t3b_done_once", 32'(done_cnt_a), 32'd1);
      check("t3b_no_error",  32'(err_a),      32'd0);

      // T4: asynchronous reset mid-STREAM at rd_addr 7
      clr_a();
      pulse_start_a();
      n = 0;
      @(negedge Clk);
      while (!(rd_en_a && rd_addr_a == AW'(7)) && n < 100) begin @(negedge Clk); n++; end
      check("t4_reach_addr7", 32'(rd_addr_a), 32'd7);
      mon_a = 0;
      #2 Rst = 1'b0;
      #1;
      check("t4_rd_en",   32'(rd_en_a),   32'd0);
      check("t4_rd_addr", 32'(rd_addr_a), 32'd0);
      check("t4_vin",     32'(vin_a),     32'd0);
      check("t4_wr_en",   32'(wr_en_a),   32'd0);
      check("t4_wr_addr", 32'(wr_addr_a), 32'd0);
      check("t4_pass",    32'(pass_a),    32'd0);
      check("t4_busy",    32'(busy_a),    32'd0);
      check("t4_done",    32'(done_a),    32'd0);
      check("t4_error",   32'(err_a),     32'd0);
      @(negedge Clk);
      Rst = 1'b1;
      // in-flight echoes arrive while idle and must not be written
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         check("t4_idle_busy",  32'(busy_a),  32'd0);
         check("t4_idle_rd_en", 32'(rd_en_a), 32'd0);
         check("t4_idle_wr_en", 32'(wr_en_a), 32'd0);
         check("t4_idle_done",  32'(done_a),  32'd0);
      end

      // T5: RD_LATENCY=3, outputs complete before the reads
      mon_b = 1;
      @(posedge Clk); #1 start_b = 1'b1;
      @(posedge Clk); #1 start_b = 1'b0;
      n = 0;
      @(negedge Clk);
      while (busy_b && n < 400) begin @(negedge Clk); n++; end
      check("t5_idle_in_budget", 32'(busy_b), 32'd0);
      check("t5_rd_count",  32'(rd_cnt_b),   32'd32);
      check("t5_wr_count",  32'(wr_cnt_b),   32'd32);
      check("t5_done_once", 32'(done_cnt_b), 32'd1);
      check("t5_out_before_rd", 32'(out_full_cyc_b >= 0 && out_full_cyc_b < rd_last_cyc_b), 32'd1);
      // last read, one NEXT cycle, then the new pass index is visible
      check("t5_next_after_reads", 32'(pass_chg_cyc_b - rd_last_cyc_b), 32'd2);
      check("t5_no_error", 32'(err_b), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/layer_4_pass_scheduler.md
Name: layer_4_pass_scheduler

Overview:
- Sequences one convolution layer: streams the input feature map from the layer input buffer into the shared featuremap array, one output-channel group ("pass") at a time.
- Generates read addresses and the aligned `valid_in` strobe for the featuremap array.
- Counts returning `valid_out` pulses, generates output-buffer write addresses, detects drain stalls, then advances to the next pass or finishes.
- Sits between the layer controller (start/done) and the featuremap array plus its input/output buffers.

Parameters:
- IMG_SIZE, 104, input feature-map width = height in pixels.
- OUT_PIXELS, 10816, `valid_out` pulses expected per pass (IMG_SIZE*IMG_SIZE for same-padding).
- NUM_PASSES, 8, output-channel groups processed sequentially.
- RD_LATENCY, 1, input-buffer read latency in cycles (1..4).
- ADDR_WIDTH, 14, width of read/write pixel addresses.
- TIMEOUT, 4096, idle cycles allowed in DRAIN before error.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; honoured only in IDLE.
- fm_ready  in  1  featuremap array can accept a pixel this cycle.
- fm_valid_out  in  1  featuremap array produced one output pixel.
- rd_en  out  1  input-buffer read enable.
- rd_addr  out  ADDR_WIDTH  input-buffer pixel address.
- fm_valid_in  out  1  `rd_en` delayed RD_LATENCY cycles; strobes data into the array.
- wr_en  out  1  equals `fm_valid_out` while in STREAM/DRAIN.
- wr_addr  out  ADDR_WIDTH  output-buffer address for the current pixel.
- pass_idx  out  8  current pass; selects the weight bank and output-buffer region.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the last pass completes.
- error  out  1  sticky drain-timeout flag; cleared by the next accepted start.

Behaviour:
- Reset (Rst=0, async):
  - state=IDLE.
  - rd_en=0, rd_addr=0, fm_valid_in=0 and the whole delay line, wr_en=0, wr_addr=0, pass_idx=0, busy=0, done=0, error=0.
  - Reset mid-pass aborts immediately; no done pulse is generated.
- FSM states: IDLE, STREAM, DRAIN, NEXT, FINISH.
- IDLE:
  - On start=1, next cycle enter STREAM.
  - pass_idx=0, counters=0, error=0.
- STREAM:
  - rd_en = fm_ready.
  - rd_addr increments only on cycles where rd_en=1.
  - After address IMG_SIZE*IMG_SIZE-1 is issued, next state is DRAIN; rd_addr returns to 0.
  - fm_ready=0 holds rd_addr with rd_en=0 (bubble). The delay line still shifts, so bubbles propagate into fm_valid_in.
- fm_valid_in:
  - Shift register of depth RD_LATENCY on rd_en.
  - Independent of state, so in-flight reads complete after leaving STREAM.
- Output side (STREAM and DRAIN):
  - Each fm_valid_out=1 gives wr_en=1 that cycle, with wr_addr = the current output count.
  - The output count increments afterwards.
  - wr_addr is combinational from the count register, so the first pixel of a pass writes address 0.
- DRAIN:
  - Exit to NEXT on the cycle the count reaches OUT_PIXELS, i.e. the OUT_PIXELS-th pulse is accepted.
  - An idle counter counts cycles with fm_valid_out=0 and resets on any pulse.
  - When it reaches TIMEOUT: set error=1 and go to FINISH.
- Output count reaching OUT_PIXELS while still in STREAM: go directly to NEXT once the read side finishes. Both conditions are tracked independently.
- fm_valid_out outside STREAM/DRAIN: ignored; wr_en=0.
- NEXT (1 cycle):
  - Output count cleared.
  - If pass_idx==NUM_PASSES-1, go to FINISH.
  - Else pass_idx++ and go to STREAM.
- FINISH (1 cycle):
  - done=1; done is suppressed if error=1.
  - Next cycle IDLE with busy=0; pass_idx holds its last value until the next start.
- start while busy: ignored.
- Latency: first rd_en appears 1 cycle after start (given fm_ready=1). The first fm_valid_in follows RD_LATENCY cycles later.

Optional Feature:
- Macro: LAYER_SCHED_PERF_EN.
- Defined:
  - Adds output `cycle_count[31:0]`, which counts every busy cycle, clears on an accepted start, and holds after FINISH.
  - Adds output `stall_count[31:0]`, which counts STREAM cycles with fm_ready=0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Basic pass, fm_ready tied 1 (IMG_SIZE=4, OUT_PIXELS=16, NUM_PASSES=2, RD_LATENCY=1), array model echoes fm_valid_in after 5 cycles:
  - rd_addr runs 0..15 twice; fm_valid_in lags rd_en by 1.
  - wr_addr runs 0..15 per pass; pass_idx goes 0→1.
  - Exactly one done pulse; busy falls the cycle after done.
- Backpressure (same config), fm_ready=0 on cycles 3,4 of STREAM:
  - rd_addr holds at 2 for those cycles, rd_en=0.
  - Total rd_en pulses per pass = 16.
  - Still completes with done.
- Drain timeout (TIMEOUT=8), model emits only 10 of 16 outputs:
  - error=1 set 8 cycles after the last pulse.
  - No done pulse; busy drops; next start clears error.
- Async reset mid-STREAM (Rst low at rd_addr=7):
  - All outputs 0 immediately, without waiting for Clk.
  - After release, no activity until start.
- start pulse issued during pass 1: ignored, and pass_idx/rd_addr sequence is unchanged.
- RD_LATENCY=3, with an outputs-before-reads-finish model: fm_valid_in lags rd_en by exactly 3 cycles, and NEXT is entered only after both the read side and the output count complete.
